// File: rtl/bus_cycle_sequencer.sv
// Machine-cycle / T-state sequencer for the 8085-class core: M1 opcode fetch plus up to
// MAX_MC-1 read/write cycles, with READY wait states and HOLD/HLDA bus release.
module bus_cycle_sequencer #(
    parameter int unsigned  MAX_MC  = 5,
    parameter bit           WAIT_EN = 1'b1,
    localparam int unsigned MC_W    = $clog2(MAX_MC),
    localparam int unsigned TY_W    = 2 * (MAX_MC - 1)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            ready,
    input  logic            hold,
    input  logic            desc_lng,
    input  logic [MC_W-1:0] desc_ncyc,
    input  logic [TY_W-1:0] desc_types,
    output logic [3:0]      t_state,
    output logic [MC_W-1:0] mc_index,
    output logic            ale,
    output logic            rd_n,
    output logic            wr_n,
    output logic            io_m_n,
    output logic            s1,
    output logic            s0,
    output logic            hlda,
    output logic            fetch_strobe,
    output logic            desc_take,
    output logic            instr_done
);

    typedef enum logic [3:0] {
        TRESET = 4'd0,
        T1     = 4'd1,
        T2     = 4'd2,
        T3     = 4'd3,
        T4     = 4'd4,
        T5     = 4'd5,
        T6     = 4'd6,
        TW     = 4'd7,
        THOLD  = 4'd8
    } tstate_e;

    tstate_e         state_q, state_d;
    logic [MC_W-1:0] mc_q, mc_d;
    logic [MC_W-1:0] pend_q, pend_d;
    logic [MC_W-1:0] ncyc_q, ncyc_d;
    logic [MC_W-1:0] ncyc_clamp;
    logic [MC_W-1:0] mc_next;
    logic            lng_q, lng_d;
    logic [TY_W-1:0] types_q, types_d;
    logic            boundary;

    logic            ale_q, ale_d;
    logic            rd_n_q, rd_n_d;
    logic            wr_n_q, wr_n_d;
    logic            io_m_n_q, io_m_n_d;
    logic [1:0]      stat_q, stat_d;
    logic            hlda_q, hlda_d;
    logic            fetch_q, fetch_d;
    logic            take_q, take_d;
    logic            done_q, done_d;

    logic            m1_d;
    logic [1:0]      ty_d;
    logic            bus_ph;
    logic            addr_ph;
    logic            in_cyc;

    // Type field of machine cycle k (k >= 1); M1 has no entry in the table.
    function automatic logic [1:0] cyc_type(input logic [TY_W-1:0] ty, input logic [MC_W-1:0] k);
        logic [TY_W-1:0] sh;
        sh = (k == '0) ? '0 : (ty >> (2 * (32'(k) - 32'd1)));
        return sh[1:0];
    endfunction

    assign ncyc_clamp = (desc_ncyc > MC_W'(MAX_MC - 1)) ? MC_W'(MAX_MC - 1) : desc_ncyc;

    // Next-state: T-state walk, descriptor capture and cycle-boundary / hold handling.
    always_comb begin
        state_d  = state_q;
        mc_d     = mc_q;
        pend_d   = pend_q;
        lng_d    = lng_q;
        ncyc_d   = ncyc_q;
        types_d  = types_q;
        boundary = 1'b0;
        mc_next  = '0;

        case (state_q)
            TRESET: begin
                state_d = T1;
                mc_d    = '0;
            end
            T1:      state_d = T2;
            T2, TW:  state_d = (WAIT_EN && !ready) ? TW : T3;
            T3: begin
                if (mc_q == '0) begin
                    state_d = T4;
                end else begin
                    boundary = 1'b1;
                end
            end
            T4: begin
                lng_d   = desc_lng;
                ncyc_d  = ncyc_clamp;
                types_d = desc_types;
                if (desc_lng) begin
                    state_d = T5;
                end else begin
                    boundary = 1'b1;
                end
            end
            T5:      state_d = T6;
            T6:      boundary = 1'b1;
            THOLD: begin
                if (!hold) begin
                    state_d = T1;
                    mc_d    = pend_q;
                end
            end
            default: state_d = TRESET;
        endcase

        if (boundary) begin
            mc_next = (mc_q < ncyc_d) ? mc_q + MC_W'(1) : '0;
            if (hold) begin
                state_d = THOLD;
                pend_d  = mc_next;
            end else begin
                state_d = T1;
                mc_d    = mc_next;
            end
        end
    end

    // Output decode of the next state, so registered outputs line up with t_state.
    always_comb begin
        m1_d     = (mc_d == '0);
        ty_d     = m1_d ? 2'b00 : cyc_type(types_d, mc_d);
        bus_ph   = (state_d inside {T2, TW, T3});
        addr_ph  = (state_d inside {T1, T2, TW, T3});
        in_cyc   = (state_d inside {T1, T2, TW, T3, T4, T5, T6});

        ale_d    = (state_d == T1);
        rd_n_d   = !(bus_ph && (m1_d || !ty_d[0]));
        wr_n_d   = !(bus_ph && !m1_d && ty_d[0]);
        io_m_n_d = addr_ph && !m1_d && ty_d[1];
        stat_d   = 2'b00;
        if (in_cyc) begin
            stat_d = m1_d ? 2'b11 : (ty_d[0] ? 2'b01 : 2'b10);
        end
        hlda_d   = (state_d == THOLD);
        fetch_d  = (state_d == T3) && m1_d;
        take_d   = (state_d == T4);
        // Entering T4 the descriptor for this instruction is already on the inputs.
        done_d   = ((state_d == T4) && !desc_lng && (ncyc_clamp == '0))
                || ((state_d == T6) && lng_d && (ncyc_d == '0))
                || ((state_d == T3) && !m1_d && (mc_d == ncyc_d));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= TRESET;
            mc_q     <= '0;
            pend_q   <= '0;
            lng_q    <= 1'b0;
            ncyc_q   <= '0;
            types_q  <= '0;
            ale_q    <= 1'b0;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
            io_m_n_q <= 1'b0;
            stat_q   <= 2'b00;
            hlda_q   <= 1'b0;
            fetch_q  <= 1'b0;
            take_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mc_q     <= mc_d;
            pend_q   <= pend_d;
            lng_q    <= lng_d;
            ncyc_q   <= ncyc_d;
            types_q  <= types_d;
            ale_q    <= ale_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
            io_m_n_q <= io_m_n_d;
            stat_q   <= stat_d;
            hlda_q   <= hlda_d;
            fetch_q  <= fetch_d;
            take_q   <= take_d;
            done_q   <= done_d;
        end
    end

    assign t_state      = state_q;
    assign mc_index     = mc_q;
    assign ale          = ale_q;
    assign rd_n         = rd_n_q;
    assign wr_n         = wr_n_q;
    assign io_m_n       = io_m_n_q;
    assign s1           = stat_q[1];
    assign s0           = stat_q[0];
    assign hlda         = hlda_q;
    assign fetch_strobe = fetch_q;
    assign desc_take    = take_q;
    assign instr_done   = done_q;

endmodule

// File: tb/tb_bus_cycle_sequencer.sv
// Bench for bus_cycle_sequencer: each instruction is expanded into a per-clock list of
// expected T-states and outputs, with the ready/hold inputs chosen to produce it.
module tb_bus_cycle_sequencer;

    localparam int unsigned MAX_MC = 5;
    localparam int unsigned MC_W   = $clog2(MAX_MC);
    localparam int unsigned TY_W   = 2 * (MAX_MC - 1);

    localparam logic [3:0] S_RST  = 4'd0;
    localparam logic [3:0] S_T1   = 4'd1;
    localparam logic [3:0] S_T2   = 4'd2;
    localparam logic [3:0] S_T3   = 4'd3;
    localparam logic [3:0] S_T4   = 4'd4;
    localparam logic [3:0] S_T5   = 4'd5;
    localparam logic [3:0] S_T6   = 4'd6;
    localparam logic [3:0] S_TW   = 4'd7;
    localparam logic [3:0] S_HOLD = 4'd8;

    // {ale, rd_n, wr_n, io_m_n, s1, s0, hlda, fetch_strobe, desc_take, instr_done}
    localparam logic [9:0] V_IDLE = 10'b0110000000;
    localparam logic [9:0] V_HOLD = 10'b0110001000;

    logic            clk = 1'b0;
    logic            reset;
    logic            ready;
    logic            hold;
    logic            desc_lng;
    logic [MC_W-1:0] desc_ncyc;
    logic [TY_W-1:0] desc_types;

    logic [3:0]      a_state, b_state;
    logic [MC_W-1:0] a_mc, b_mc;
    logic            a_ale, a_rd_n, a_wr_n, a_io, a_s1, a_s0, a_hlda, a_fetch, a_take, a_done;
    logic            b_ale, b_rd_n, b_wr_n, b_io, b_s1, b_s0, b_hlda, b_fetch, b_take, b_done;

    bit              sel;
    logic [3:0]      o_state;
    logic [MC_W-1:0] o_mc;
    logic [9:0]      o_vec;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic [3:0]      st;
        int              mc;
        bit              chk_mc;
        logic [9:0]      vec;
        bit              rdy;
        bit              hld;
        bit              lng;
        logic [MC_W-1:0] ncyc;
        logic [TY_W-1:0] types;
    } step_t;

    step_t q[$];

    always #5 clk = ~clk;

    bus_cycle_sequencer #(.MAX_MC(MAX_MC), .WAIT_EN(1'b1)) dut_a (
        .clk(clk), .reset(reset), .ready(ready), .hold(hold),
        .desc_lng(desc_lng), .desc_ncyc(desc_ncyc), .desc_types(desc_types),
        .t_state(a_state), .mc_index(a_mc), .ale(a_ale), .rd_n(a_rd_n), .wr_n(a_wr_n),
        .io_m_n(a_io), .s1(a_s1), .s0(a_s0), .hlda(a_hlda),
        .fetch_strobe(a_fetch), .desc_take(a_take), .instr_done(a_done)
    );

    bus_cycle_sequencer #(.MAX_MC(MAX_MC), .WAIT_EN(1'b0)) dut_b (
        .clk(clk), .reset(reset), .ready(ready), .hold(hold),
        .desc_lng(desc_lng), .desc_ncyc(desc_ncyc), .desc_types(desc_types),
        .t_state(b_state), .mc_index(b_mc), .ale(b_ale), .rd_n(b_rd_n), .wr_n(b_wr_n),
        .io_m_n(b_io), .s1(b_s1), .s0(b_s0), .hlda(b_hlda),
        .fetch_strobe(b_fetch), .desc_take(b_take), .instr_done(b_done)
    );

    always_comb begin
        if (sel) begin
            o_state = b_state;
            o_mc    = b_mc;
            o_vec   = {b_ale, b_rd_n, b_wr_n, b_io, b_s1, b_s0, b_hlda, b_fetch, b_take, b_done};
        end else begin
            o_state = a_state;
            o_mc    = a_mc;
            o_vec   = {a_ale, a_rd_n, a_wr_n, a_io, a_s1, a_s0, a_hlda, a_fetch, a_take, a_done};
        end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // Expected clock-by-clock trace of one instruction, including wait and hold clocks.
    task automatic build_instr(input bit lng, input logic [MC_W-1:0] ncyc_raw,
                               input logic [TY_W-1:0] types, input int waits[MAX_MC],
                               input int holds[MAX_MC], input bit rdy_low);
        int         n;
        int         w;
        bit         m1, is_wr, is_io, strobe, addr, last;
        logic [1:0] ty, stat;
        logic [3:0] s;
        logic [3:0] seq[$];
        step_t      r;
        n = (int'(ncyc_raw) > int'(MAX_MC - 1)) ? int'(MAX_MC - 1) : int'(ncyc_raw);
        r.lng   = lng;
        r.ncyc  = ncyc_raw;
        r.types = types;
        for (int k = 0; k <= n; k++) begin
            m1    = (k == 0);
            ty    = m1 ? 2'b00 : 2'(types >> (2 * (k - 1)));
            is_wr = !m1 && ty[0];
            is_io = !m1 && ty[1];
            stat  = m1 ? 2'b11 : (is_wr ? 2'b01 : 2'b10);
            w     = rdy_low ? 0 : waits[k];
            seq.delete();
            seq.push_back(S_T1);
            seq.push_back(S_T2);
            repeat (w) seq.push_back(S_TW);
            seq.push_back(S_T3);
            if (m1) begin
                seq.push_back(S_T4);
                if (lng) begin
                    seq.push_back(S_T5);
                    seq.push_back(S_T6);
                end
            end
            for (int i = 0; i < seq.size(); i++) begin
                s      = seq[i];
                last   = (i == seq.size() - 1);
                strobe = (s == S_T2) || (s == S_TW) || (s == S_T3);
                addr   = strobe || (s == S_T1);
                if (s == S_T2)      r.rdy = (w == 0);
                else if (s == S_TW) r.rdy = (i == w + 1);
                else                r.rdy = 1'($urandom);
                if (rdy_low) r.rdy = 1'b0;
                r.hld    = last ? (holds[k] > 0) : 1'($urandom);
                r.st     = s;
                r.mc     = k;
                r.chk_mc = 1'b1;
                r.vec    = {s == S_T1, !(strobe && !is_wr), !(strobe && is_wr), is_io && addr,
                            stat, 1'b0, m1 && (s == S_T3), m1 && (s == S_T4), last && (k == n)};
                q.push_back(r);
            end
            for (int h = 1; h <= holds[k]; h++) begin
                r.st     = S_HOLD;
                r.mc     = 0;
                r.chk_mc = 1'b0;
                r.vec    = V_HOLD;
                r.rdy    = 1'($urandom);
                r.hld    = (h < holds[k]);
                q.push_back(r);
            end
        end
    endtask

    task automatic play_one(output step_t r);
        r = q.pop_front();
        @(posedge clk);
        #1;
        check_eq("t_state", 32'(o_state), 32'(r.st));
        if (r.chk_mc) check_eq("mc_index", 32'(o_mc), 32'(r.mc));
        check_eq("outputs", 32'(o_vec), 32'(r.vec));
        ready      = r.rdy;
        hold       = r.hld;
        desc_lng   = r.lng;
        desc_ncyc  = r.ncyc;
        desc_types = r.types;
    endtask

    task automatic play_all();
        step_t r;
        while (q.size() > 0) play_one(r);
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        repeat (cycles) begin
            @(posedge clk);
            #1;
            check_eq("rst_t_state", 32'(o_state), 32'(S_RST));
            check_eq("rst_mc_index", 32'(o_mc), 32'd0);
            check_eq("rst_outputs", 32'(o_vec), 32'(V_IDLE));
        end
        reset = 1'b0;
    endtask

    initial begin
        int    w[MAX_MC];
        int    h[MAX_MC];
        step_t r;

        sel = 1'b0;
        reset = 1'b1; ready = 1'b1; hold = 1'b0;
        desc_lng = 1'b0; desc_ncyc = '0; desc_types = '0;
        w = '{default: 0};
        h = '{default: 0};
        do_reset(3);

        // Short M1-only instruction, then long M1 with a read and an io-write cycle.
        build_instr(1'b0, MC_W'(0), TY_W'(0), w, h, 1'b0);
        build_instr(1'b1, MC_W'(2), TY_W'(8'b0000_1100), w, h, 1'b0);
        play_all();

        // Two wait states in M1.
        w[0] = 2;
        build_instr(1'b0, MC_W'(0), TY_W'(0), w, h, 1'b0);
        play_all();
        w[0] = 0;

        // Bus released for three clocks after mc1, then hold with the instruction end.
        h[1] = 3;
        build_instr(1'b0, MC_W'(2), TY_W'(8'b0000_0100), w, h, 1'b0);
        h[1] = 0;
        h[0] = 2;
        build_instr(1'b0, MC_W'(0), TY_W'(0), w, h, 1'b0);
        h[0] = 0;
        play_all();

        // Oversized cycle count clamps to MAX_MC-1.
        build_instr(1'b1, MC_W'(7), TY_W'(8'b1110_0100), w, h, 1'b0);
        play_all();

        for (int i = 0; i < 30; i++) begin
            for (int k = 0; k < MAX_MC; k++) begin
                w[k] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0;
                h[k] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 3)) : 0;
            end
            build_instr(1'($urandom), MC_W'($urandom_range(0, 7)), TY_W'($urandom), w, h, 1'b0);
            play_all();
        end
        w = '{default: 0};
        h = '{default: 0};

        // Reset in the middle of an mc1 wait state wins over hold and ready.
        w[1] = 3;
        build_instr(1'b0, MC_W'(1), TY_W'(8'b0000_0010), w, h, 1'b0);
        while (q.size() > 0) begin
            play_one(r);
            if (r.st == S_TW && r.mc == 1) break;
        end
        q.delete();
        ready = 1'b0;
        hold  = 1'b1;
        do_reset(1);
        hold  = 1'b0;
        ready = 1'b1;
        w[1] = 0;
        build_instr(1'b0, MC_W'(1), TY_W'(8'b0000_0011), w, h, 1'b0);
        play_all();

        // WAIT_EN=0 instance: ready held low must never produce TW.
        sel = 1'b1;
        do_reset(2);
        build_instr(1'b0, MC_W'(0), TY_W'(0), w, h, 1'b1);
        build_instr(1'b1, MC_W'(3), TY_W'(8'b0010_1101), w, h, 1'b1);
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < MAX_MC; k++) begin
                h[k] = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
            end
            build_instr(1'($urandom), MC_W'($urandom_range(0, 7)), TY_W'($urandom), w, h, 1'b1);
        end
        play_all();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
